// File: rtl/os_array_drain.sv
// os_array_drain: job controller and row-wise result reader for an output-stationary MAC array.
// Waits out the array fill/skew latency, streams one result row per handshake, then clears the array.
// Build macro OS_DRAIN_SNAPSHOT_EN: capture the array into shadow registers right after compute
// (clearing the array in the same cycle) and drain from the shadow copy instead of the live array.
module os_array_drain #(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned K_WIDTH        = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [K_WIDTH-1:0]                  k_len_i,
    output logic                                busy_o,
    output logic                                done_o,
    input  logic [ROWS*COLS*DATA_WIDTH_OUT-1:0] mac_res_i,
    output logic                                clear_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [COLS*DATA_WIDTH_OUT-1:0]      out_data_o,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row_o,
    output logic                                out_last_o
);

    localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned RowBits = COLS * DATA_WIDTH_OUT;
    localparam int unsigned ArrBits = ROWS * COLS * DATA_WIDTH_OUT;
    // Wide enough for k_len + ROWS + COLS - 1 at the largest k_len.
    localparam int unsigned CntW    = K_WIDTH + $clog2(ROWS + COLS) + 1;
    localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

    typedef enum logic [2:0] {StIdle, StCompute, StSnap, StDrain, StClear} state_e;

    state_e              state_q;
    logic [K_WIDTH-1:0]  k_q;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     limit;
    logic [RowW-1:0]     row_q;
    logic                busy_q;
    logic                valid_q;
    logic                clear_q;
    logic [ArrBits-1:0]  src;
    logic [RowBits-1:0]  row_data;

    // Counter runs 0..N-1 through COMPUTE, so the last compute cycle sees cnt == N-1.
    assign limit = CntW'(k_q) + CntW'(ROWS + COLS - 2);

`ifdef OS_DRAIN_SNAPSHOT_EN
    logic [ArrBits-1:0] shadow_q;
    assign src    = shadow_q;
    // Job completes on the last-row handshake itself.
    assign done_o = valid_q & out_ready_i & (row_q == LastRow);
`else
    logic done_q;
    assign src    = mac_res_i;
    assign done_o = done_q;
`endif

    // Job FSM with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            k_q      <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            clear_q  <= 1'b0;
`ifdef OS_DRAIN_SNAPSHOT_EN
            shadow_q <= '0;
`else
            done_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        k_q     <= k_len_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCompute;
                    end
                end
                StCompute: begin
                    if (cnt_q == limit) begin
`ifdef OS_DRAIN_SNAPSHOT_EN
                        clear_q <= 1'b1;
                        state_q <= StSnap;
`else
                        valid_q <= 1'b1;
                        row_q   <= '0;
                        state_q <= StDrain;
`endif
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`ifdef OS_DRAIN_SNAPSHOT_EN
                StSnap: begin
                    shadow_q <= mac_res_i;
                    clear_q  <= 1'b0;
                    valid_q  <= 1'b1;
                    row_q    <= '0;
                    state_q  <= StDrain;
                end
`endif
                StDrain: begin
                    // valid_q is high throughout DRAIN, so ready alone completes a handshake.
                    if (out_ready_i) begin
                        if (row_q == LastRow) begin
                            valid_q <= 1'b0;
                            row_q   <= '0;
`ifdef OS_DRAIN_SNAPSHOT_EN
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
`else
                            clear_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StClear;
`endif
                        end else begin
                            row_q <= row_q + RowW'(1);
                        end
                    end
                end
`ifndef OS_DRAIN_SNAPSHOT_EN
                StClear: begin
                    clear_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    // Select the current row out of the flattened result array.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == RowW'(r)) begin
                row_data = src[r*RowBits +: RowBits];
            end
        end
    end

    assign busy_o      = busy_q;
    assign clear_o     = clear_q;
    assign out_valid_o = valid_q;
    assign out_row_o   = row_q;
    assign out_last_o  = valid_q & (row_q == LastRow);
    assign out_data_o  = valid_q ? row_data : '0;

endmodule

// File: tb/tb_os_array_drain.sv
// Directed bench for os_array_drain (ROWS=COLS=4, 32-bit results, 16-bit K).
module tb_os_array_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 32;
    localparam int KW   = 16;

    localparam int PH_COMP  = 0;
    localparam int PH_SNAP  = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_CLEAR = 3;
    localparam int PH_IDLE  = 4;

`ifdef OS_DRAIN_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [KW-1:0]           k_len;
    logic                    busy;
    logic                    done;
    logic [ROWS*COLS*DW-1:0] mac_res;
    logic                    clear;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*DW-1:0]      out_data;
    logic [1:0]              out_row;
    logic                    out_last;

    int n_cmp = 0;
    int n_err = 0;

    os_array_drain #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DATA_WIDTH_OUT(DW),
        .K_WIDTH(KW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .k_len_i(k_len),
        .busy_o(busy),
        .done_o(done),
        .mac_res_i(mac_res),
        .clear_o(clear),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o(out_data),
        .out_row_o(out_row),
        .out_last_o(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode 0: PE(r,c) = 0x100*r + c. Mode 1: PE(r,c) = r*4 + c.
    function automatic logic [DW-1:0] pe_val(input int mode, input int r, input int c);
        if (mode == 0) return DW'(256 * r + c);
        return DW'(r * 4 + c);
    endfunction

    function automatic logic [ROWS*COLS*DW-1:0] pattern(input int mode);
        logic [ROWS*COLS*DW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*DW +: DW] = pe_val(mode, r, c);
        return v;
    endfunction

    function automatic logic [COLS*DW-1:0] exp_row(input int mode, input int r);
        logic [COLS*DW-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*DW +: DW] = pe_val(mode, r, c);
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One job from start (cycle t) to three idle cycles. exp_fv is the hand-computed first
    // out_valid cycle relative to t; ready is low for rel in [lo,hi]; start pulses at s1/s2.
    task automatic run_job(input string name, input logic [KW-1:0] k, input int exp_fv,
                           input int mode, input int lo, input int hi, input int hold_row,
                           input logic [127:0] hold_data, input int s1, input int s2);
        int ph, row, rows, dones, first_v, idle_n;
        ph = PH_COMP; row = 0; rows = 0; dones = 0; first_v = -1; idle_n = 0;
        mac_res   = pattern(mode);
        out_ready = 1'b1;
        start     = 1'b1;
        k_len     = k;
        @(negedge clk);
        check({name, " busy before start"}, 128'(busy), 128'(0));
        next_cycle();
        start = 1'b0;
        for (int rel = 1; rel <= exp_fv + 40 && idle_n < 3; rel++) begin
            start     = (rel == s1) || (rel == s2);
            out_ready = !(rel >= lo && rel <= hi);
            if (ph == PH_DRAIN || ph == PH_IDLE) mac_res = SNAP ? '0 : pattern(mode);
            @(negedge clk);
            if (out_valid && first_v < 0) first_v = rel;
            if (out_valid && out_ready) rows++;
            if (done) dones++;
            if (ph != PH_COMP || rel < 20 || rel >= exp_fv - 3) begin
                check({name, " busy"}, 128'(busy), 128'(ph != PH_IDLE));
                check({name, " valid"}, 128'(out_valid), 128'(ph == PH_DRAIN));
                check({name, " clear"}, 128'(clear),
                      128'(SNAP ? (ph == PH_SNAP) : (ph == PH_CLEAR)));
                check({name, " done"}, 128'(done),
                      128'(SNAP ? (ph == PH_DRAIN && row == ROWS - 1 && out_ready)
                                : (ph == PH_CLEAR)));
                check({name, " last"}, 128'(out_last), 128'(ph == PH_DRAIN && row == ROWS - 1));
            end
            if (ph == PH_DRAIN) begin
                check({name, " row"}, 128'(out_row), 128'(row));
                check({name, " data"}, 128'(out_data), 128'(exp_row(mode, row)));
                if (rel >= lo && rel <= hi) begin
                    check({name, " held row"}, 128'(out_row), 128'(hold_row));
                    check({name, " held data"}, 128'(out_data), hold_data);
                end
            end
            case (ph)
                PH_COMP: begin
                    if (!SNAP && rel + 1 == exp_fv) ph = PH_DRAIN;
                    else if (SNAP && rel + 2 == exp_fv) ph = PH_SNAP;
                end
                PH_SNAP: ph = PH_DRAIN;
                PH_DRAIN: begin
                    if (out_ready) begin
                        if (row == ROWS - 1) ph = SNAP ? PH_IDLE : PH_CLEAR;
                        else row++;
                    end
                end
                PH_CLEAR: ph = PH_IDLE;
                default: idle_n++;
            endcase
            next_cycle();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({name, " completed"}, 128'(ph == PH_IDLE), 128'(1));
        check({name, " first valid cycle"}, 128'(first_v), 128'(exp_fv));
        check({name, " rows out"}, 128'(rows), 128'(ROWS));
        check({name, " done pulses"}, 128'(dones), 128'(1));
    endtask

    // Reset asserted for two cycles while DRAIN is stalled; start held high during reset.
    task automatic reset_mid_drain();
        mac_res   = pattern(0);
        out_ready = 1'b0;
        start     = 1'b1;
        k_len     = '0;
        next_cycle();
        start = 1'b0;
        for (int i = 1; i < 10; i++) next_cycle();
        @(negedge clk);
        check("mid drain valid", 128'(out_valid), 128'(1));
        next_cycle();
        rst   = 1'b1;
        start = 1'b1;
        next_cycle();
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("post reset busy", 128'(busy), 128'(0));
        check("post reset valid", 128'(out_valid), 128'(0));
        check("post reset clear", 128'(clear), 128'(0));
        check("post reset done", 128'(done), 128'(0));
        check("post reset row", 128'(out_row), 128'(0));
        out_ready = 1'b1;
        next_cycle();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        k_len     = 16'd5;
        out_ready = 1'b1;
        mac_res   = pattern(0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset clear", 128'(clear), 128'(0));
        check("reset valid", 128'(out_valid), 128'(0));
        check("reset last", 128'(out_last), 128'(0));
        check("reset row", 128'(out_row), 128'(0));
        check("reset data", 128'(out_data), 128'(0));
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start during reset ignored", 128'(busy), 128'(0));
        next_cycle();

`ifndef OS_DRAIN_SNAPSHOT_EN
        run_job("k8 stray starts", 16'd8, 16, 0, 0, -1, 0, '0, 5, 17);
        run_job("backpressure", 16'd8, 16, 0, 17, 19, 1,
                128'h00000103_00000102_00000101_00000100, 0, 0);
        run_job("k0", 16'd0, 8, 0, 0, -1, 0, '0, 0, 0);
        reset_mid_drain();
        run_job("after reset", 16'd3, 11, 0, 0, -1, 0, '0, 0, 0);
        run_job("kmax", 16'hFFFF, 65543, 0, 0, -1, 0, '0, 0, 0);
`else
        run_job("snap k8", 16'd8, 17, 1, 0, -1, 0, '0, 5, 18);
        run_job("snap backpressure", 16'd0, 9, 1, 9, 11, 0,
                128'h00000003_00000002_00000001_00000000, 0, 0);
        reset_mid_drain();
        run_job("snap after reset", 16'd3, 12, 1, 0, -1, 0, '0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
